posit_regime_decoder_pipe: RTL and testbench

Pipelined, handshaked posit field decoder that generalises the combinational leading-bit detector into a full regime/exponent/fraction extractor. It accepts one packed posit per cycle, takes the absolute value, measures the regime run, and emits sign, signed regime k, aligned exponent and fraction, plus zero/NaR flags. It sits at the front of the PPU arithmetic datapath, between operand fetch and the posit add/mul cores, with valid/ready backpressure.

---
 rtl/posit_regime_decoder_pipe.sv | 205 ++++++++++++++++++++
 tb/tb_posit_regime_decoder_pipe.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_regime_decoder_pipe.sv
// Pipelined posit decoder: sign, signed regime k, exponent, fraction and zero/NaR flags.
// Define POSIT_REGDEC_MIDREG_EN to add a register between run detection and field extraction.
package posit_pkg;

    typedef enum logic [1:0] {
        POSIT8_ES2  = 2'd0,
        POSIT16_ES2 = 2'd1,
        POSIT32_ES2 = 2'd2,
        POSIT16_ES1 = 2'd3
    } posit_format_e;

    function automatic int posit_width(input posit_format_e f);
        case (f)
            POSIT8_ES2:               return 8;
            POSIT16_ES2, POSIT16_ES1: return 16;
            default:                  return 32;
        endcase
    endfunction

    function automatic int exp_bits(input posit_format_e f);
        case (f)
            POSIT16_ES1: return 1;
            default:     return 2;
        endcase
    endfunction

endpackage

module posit_regime_decoder_pipe #(
    parameter posit_pkg::posit_format_e pFormat = posit_pkg::posit_format_e'(0),
    localparam int N  = posit_pkg::posit_width(pFormat),
    localparam int ES = posit_pkg::exp_bits(pFormat),
    localparam int RS = $clog2(N),
    localparam int FW = N - 1 - ES
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [N-1:0]  operand_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic          sign_o,
    output logic [RS:0]   k_o,
    output logic [ES-1:0] exp_o,
    output logic [FW-1:0] frac_o,
    output logic          is_zero_o,
    output logic          is_nar_o
);

    // Handshake: a transfer happens on a rising edge where valid && ready. Each stage
    // loads when empty or when its consumer takes its current item; valid never drops
    // without a transfer except on flush_i or rst_i. flush_i beats a same-cycle accept.

    // Stage A: sign, magnitude, specials and regime run length.
    logic          a_sign;
    logic          a_zero;
    logic          a_nar;
    logic          a_rc;
    logic          a_counting;
    logic [N-2:0]  a_body;
    logic [RS-1:0] a_run;

    always_comb begin
        a_sign     = operand_i[N-1];
        // Low bits of the two's complement only depend on low operand bits.
        a_body     = a_sign ? -operand_i[N-2:0] : operand_i[N-2:0];
        a_zero     = (operand_i == '0);
        a_nar      = operand_i[N-1] && (operand_i[N-2:0] == '0);
        a_rc       = a_body[N-2];
        a_run      = '0;
        a_counting = 1'b1;
        for (int i = N - 2; i >= 0; i--) begin
            if (a_counting && (a_body[i] == a_rc)) begin
                a_run = a_run + RS'(1);
            end else begin
                a_counting = 1'b0;
            end
        end
    end

    // Stage B inputs: either the mid register or stage A directly.
    logic          en_b;
    logic          b_valid;
    logic          b_sign;
    logic          b_zero;
    logic          b_nar;
    logic          b_rc;
    logic [N-2:0]  b_body;
    logic [RS-1:0] b_run;

    assign en_b = !out_valid_o || out_ready_i;

`ifdef POSIT_REGDEC_MIDREG_EN
    logic          en_a;
    logic          mid_valid_q;
    logic          mid_sign_q;
    logic          mid_zero_q;
    logic          mid_nar_q;
    logic          mid_rc_q;
    logic [N-2:0]  mid_body_q;
    logic [RS-1:0] mid_run_q;

    assign en_a       = !mid_valid_q || en_b;
    assign in_ready_o = en_a;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mid_valid_q <= 1'b0;
        end else if (flush_i) begin
            mid_valid_q <= 1'b0;
        end else if (en_a) begin
            mid_valid_q <= in_valid_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mid_sign_q <= 1'b0;
            mid_zero_q <= 1'b0;
            mid_nar_q  <= 1'b0;
            mid_rc_q   <= 1'b0;
            mid_body_q <= '0;
            mid_run_q  <= '0;
        end else if (en_a && in_valid_i) begin
            mid_sign_q <= a_sign;
            mid_zero_q <= a_zero;
            mid_nar_q  <= a_nar;
            mid_rc_q   <= a_rc;
            mid_body_q <= a_body;
            mid_run_q  <= a_run;
        end
    end

    assign b_valid = mid_valid_q;
    assign b_sign  = mid_sign_q;
    assign b_zero  = mid_zero_q;
    assign b_nar   = mid_nar_q;
    assign b_rc    = mid_rc_q;
    assign b_body  = mid_body_q;
    assign b_run   = mid_run_q;
`else
    assign in_ready_o = en_b;
    assign b_valid    = in_valid_i;
    assign b_sign     = a_sign;
    assign b_zero     = a_zero;
    assign b_nar      = a_nar;
    assign b_rc       = a_rc;
    assign b_body     = a_body;
    assign b_run      = a_run;
`endif

    // Stage B: regime value, drop regime + terminator, split exponent and fraction.
    logic [RS:0]   b_shamt;
    logic [N-2:0]  b_rem;
    logic          b_sign_res;
    logic [RS:0]   b_k;
    logic [ES-1:0] b_exp;
    logic [FW-1:0] b_frac;

    always_comb begin
        b_shamt    = {1'b0, b_run} + (RS + 1)'(1);
        b_rem      = b_body << b_shamt;
        b_k        = b_rc ? ({1'b0, b_run} - (RS + 1)'(1)) : -{1'b0, b_run};
        b_exp      = b_rem[N-2 -: ES];
        b_frac     = b_rem[FW-1:0];
        b_sign_res = b_sign;
        if (b_zero || b_nar) begin
            b_k        = '0;
            b_exp      = '0;
            b_frac     = '0;
            b_sign_res = b_nar;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (en_b) begin
            out_valid_o <= b_valid;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sign_o    <= 1'b0;
            k_o       <= '0;
            exp_o     <= '0;
            frac_o    <= '0;
            is_zero_o <= 1'b0;
            is_nar_o  <= 1'b0;
        end else if (en_b && b_valid) begin
            sign_o    <= b_sign_res;
            k_o       <= b_k;
            exp_o     <= b_exp;
            frac_o    <= b_frac;
            is_zero_o <= b_zero;
            is_nar_o  <= b_nar;
        end
    end

endmodule

// File: tb/tb_posit_regime_decoder_pipe.sv
// Directed bench for posit_regime_decoder_pipe in the posit<8,2> format.
// Honors POSIT_REGDEC_MIDREG_EN for expected latency and buffering depth.
module tb_posit_regime_decoder_pipe;

    localparam int W = 14;
`ifdef POSIT_REGDEC_MIDREG_EN
    localparam int LAT   = 2;
    localparam int DEPTH = 2;
`else
    localparam int LAT   = 1;
    localparam int DEPTH = 1;
`endif

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       flush     = 1'b0;
    logic       in_valid  = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] operand   = 8'h00;

    logic       in_ready_o;
    logic       out_valid_o;
    logic       sign_o;
    logic [3:0] k_o;
    logic [1:0] exp_o;
    logic [4:0] frac_o;
    logic       is_zero_o;
    logic       is_nar_o;

    logic [W-1:0] exp_q[$];
    logic [7:0]   vec_op[12];
    logic [W-1:0] vec_exp[12];
    int           n_checks = 0;
    int           n_fail   = 0;

    wire [W-1:0] obs = {sign_o, k_o, exp_o, frac_o, is_zero_o, is_nar_o};

    posit_regime_decoder_pipe dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready_o),
        .operand_i   (operand),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready),
        .sign_o      (sign_o),
        .k_o         (k_o),
        .exp_o       (exp_o),
        .frac_o      (frac_o),
        .is_zero_o   (is_zero_o),
        .is_nar_o    (is_nar_o)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(input logic s, input logic [3:0] k, input logic [1:0] e,
                                        input logic [4:0] f, input logic z, input logic n);
        return {s, k, e, f, z, n};
    endfunction

    task automatic init_tables();
        vec_op[0]  = 8'h40; vec_exp[0]  = mk(1'b0, 4'h0, 2'b00, 5'b00000, 1'b0, 1'b0);
        vec_op[1]  = 8'h5A; vec_exp[1]  = mk(1'b0, 4'h0, 2'b11, 5'b01000, 1'b0, 1'b0);
        vec_op[2]  = 8'h7F; vec_exp[2]  = mk(1'b0, 4'h6, 2'b00, 5'b00000, 1'b0, 1'b0);
        vec_op[3]  = 8'h01; vec_exp[3]  = mk(1'b0, 4'hA, 2'b00, 5'b00000, 1'b0, 1'b0);
        vec_op[4]  = 8'hC0; vec_exp[4]  = mk(1'b1, 4'h0, 2'b00, 5'b00000, 1'b0, 1'b0);
        vec_op[5]  = 8'h00; vec_exp[5]  = mk(1'b0, 4'h0, 2'b00, 5'b00000, 1'b1, 1'b0);
        vec_op[6]  = 8'h80; vec_exp[6]  = mk(1'b1, 4'h0, 2'b00, 5'b00000, 1'b0, 1'b1);
        vec_op[7]  = 8'h30; vec_exp[7]  = mk(1'b0, 4'hF, 2'b10, 5'b00000, 1'b0, 1'b0);
        vec_op[8]  = 8'hA6; vec_exp[8]  = mk(1'b1, 4'h0, 2'b11, 5'b01000, 1'b0, 1'b0);
        vec_op[9]  = 8'h13; vec_exp[9]  = mk(1'b0, 4'hE, 2'b00, 5'b11000, 1'b0, 1'b0);
        vec_op[10] = 8'h7E; vec_exp[10] = mk(1'b0, 4'h5, 2'b00, 5'b00000, 1'b0, 1'b0);
        vec_op[11] = 8'h71; vec_exp[11] = mk(1'b0, 4'h2, 2'b00, 5'b10000, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({out_valid_o, obs} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", {out_valid_o, obs});
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready_o);
        end
    endtask

    task automatic test_decode();
        int lat;
        for (int v = 0; v < 12; v++) begin
            @(negedge clk);
            in_valid = 1'b1; operand = vec_op[v]; out_ready = 1'b1;
            #1;
            n_checks++;
            if (in_ready_o !== 1'b1) begin
                n_fail++; $display("FAIL decode_in_ready op %h: got %b expected 1", vec_op[v], in_ready_o);
            end
            @(negedge clk);
            in_valid = 1'b0;
            lat = 1;
            while (out_valid_o !== 1'b1 && lat < 8) begin
                @(negedge clk);
                lat++;
            end
            n_checks++;
            if (lat != LAT) begin
                n_fail++; $display("FAIL decode_latency op %h: got %0d expected %0d", vec_op[v], lat, LAT);
            end
            n_checks++;
            if (obs !== vec_exp[v]) begin
                n_fail++; $display("FAIL decode_fields op %h: got %h expected %h", vec_op[v], obs, vec_exp[v]);
            end
        end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int got = 0;
        int occ = 0;
        int cyc = 0;
        bit saw_stall = 1'b0;
        bit held = 1'b0;
        bit seen_extra = 1'b0;
        logic exp_ready;
        logic [W-1:0] held_obs;
        logic [W-1:0] e;
        exp_q.delete();
        while (got < 4 && cyc < 40) begin
            @(negedge clk);
            out_ready = !(cyc >= 2 && cyc <= 4);
            in_valid  = (sent < 4);
            operand   = vec_op[sent];
            #1;
            if (held) begin
                n_checks++;
                if (out_valid_o !== 1'b1 || obs !== held_obs) begin
                    n_fail++; $display("FAIL bp_hold: got v=%b %h expected v=1 %h", out_valid_o, obs, held_obs);
                end
            end
            exp_ready = (occ < DEPTH) || out_ready;
            n_checks++;
            if (in_ready_o !== exp_ready) begin
                n_fail++; $display("FAIL bp_in_ready cyc %0d: got %b expected %b", cyc, in_ready_o, exp_ready);
            end
            if (in_valid && !in_ready_o) saw_stall = 1'b1;
            if (in_valid && in_ready_o) begin
                exp_q.push_back(vec_exp[sent]);
                sent++;
                occ++;
            end
            held = 1'b0;
            if (out_valid_o) begin
                if (out_ready) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++; $display("FAIL bp_extra: got %h expected nothing", obs);
                    end else begin
                        e = exp_q.pop_front();
                        if (obs !== e) begin
                            n_fail++; $display("FAIL bp_order: got %h expected %h", obs, e);
                        end
                    end
                    got++;
                    occ--;
                end else begin
                    held = 1'b1;
                    held_obs = obs;
                end
            end
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_checks++;
        if (got != 4 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL bp_count: got %0d delivered expected 4 (left %0d)", got, exp_q.size());
        end
        n_checks++;
        if (!saw_stall) begin
            n_fail++; $display("FAIL bp_stall: got no in_ready drop expected one");
        end
        repeat (3) begin
            @(negedge clk);
            if (out_valid_o === 1'b1) seen_extra = 1'b1;
        end
        n_checks++;
        if (seen_extra) begin
            n_fail++; $display("FAIL bp_duplicate: got extra out_valid expected none");
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int got = 0;
        int cyc = 0;
        logic [W-1:0] e;
        exp_q.delete();
        out_ready = 1'b1;
        while (got < 6 && cyc < 40) begin
            @(negedge clk);
            in_valid = (sent < 6);
            operand  = vec_op[4 + sent];
            #1;
            if (in_valid) begin
                n_checks++;
                if (in_ready_o !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_in_ready cyc %0d: got %b expected 1", cyc, in_ready_o);
                end
                if (in_ready_o) begin
                    exp_q.push_back(vec_exp[4 + sent]);
                    sent++;
                end
            end
            if (out_valid_o) begin
                n_checks++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                if (obs !== e) begin
                    n_fail++; $display("FAIL b2b_order: got %h expected %h", obs, e);
                end
                got++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (cyc != 6 + LAT) begin
            n_fail++; $display("FAIL b2b_throughput: got %0d cycles expected %0d", cyc, 6 + LAT);
        end
    endtask

    task automatic test_flush();
        bit seen = 1'b0;
        int lat;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; operand = 8'h40;
        @(negedge clk);
        operand = 8'h7F;
        @(negedge clk);
        n_checks++;
        if (out_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL flush_pre_valid: got %b expected 1", out_valid_o);
        end
        flush = 1'b1; operand = 8'h01;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL flush_out_valid: got %b expected 0", out_valid_o);
        end
        n_checks++;
        if (in_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL flush_in_ready: got %b expected 1", in_ready_o);
        end
        out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (out_valid_o === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++; $display("FAIL flush_leak: got out_valid expected none");
        end
        // Flush coinciding with an accept into an empty pipe.
        flush = 1'b1; in_valid = 1'b1; operand = 8'h5A;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid_o === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++; $display("FAIL flush_accept: got out_valid expected none");
        end
        in_valid = 1'b1; operand = vec_op[9];
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid_o !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat != LAT || obs !== vec_exp[9]) begin
            n_fail++; $display("FAIL flush_recover: got lat %0d %h expected lat %0d %h", lat, obs, LAT, vec_exp[9]);
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        int lat;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; operand = 8'h5A;
        @(negedge clk);
        operand = 8'h71;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_pre_valid: got %b expected 1", out_valid_o);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid_o, obs} !== '0) begin
            n_fail++; $display("FAIL rstmid_async: got %h expected 0", {out_valid_o, obs});
        end
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (out_valid_o === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++; $display("FAIL rstmid_leak: got out_valid expected none");
        end
        in_valid = 1'b1; operand = vec_op[11];
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid_o !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat != LAT || obs !== vec_exp[11]) begin
            n_fail++; $display("FAIL rstmid_recover: got lat %0d %h expected lat %0d %h", lat, obs, LAT, vec_exp[11]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        init_tables();
        test_reset();
        test_decode();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
